id_ex_stage: RTL and testbench

- ID/EX pipeline register of the RISC-V core. It sits directly upstream of the ALU and drives its a, b and alu_ctrl inputs.
- Latches decoded operands and control from decode.
- Resolves EX/MEM and MEM/WB operand forwarding at its outputs.
- Detects load-use hazards, reports them to the front end, and inserts a bubble when one occurs.

---
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, resolves EX/MEM and MEM/WB
// forwarding at its outputs, and detects load-use hazards (inserting a bubble when they occur).
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1_addr,
    input  logic [RADDR-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_use_imm,
    input  logic [3:0]       id_alu_ctrl,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,

    input  logic             stall,
    input  logic             flush,

    input  logic [RADDR-1:0] exmem_rd,
    input  logic             exmem_reg_write,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic             memwb_reg_write,
    input  logic [XLEN-1:0]  memwb_result,

    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [3:0]       ex_alu_ctrl,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             load_use_hazard
);

    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] rs1_addr;
        logic [RADDR-1:0] rs2_addr;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic             use_imm;
        logic [3:0]       alu_ctrl;
        logic [RADDR-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } stage_t;

    stage_t stage_q, stage_d;

    logic             exmem_fwd_rs1, memwb_fwd_rs1;
    logic             exmem_fwd_rs2, memwb_fwd_rs2;
    logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
    logic             ex_rd_hit;

    // Control outputs are gated by valid so a bubble never writes or touches memory.
    assign ex_valid     = stage_q.valid;
    assign ex_alu_ctrl  = stage_q.alu_ctrl;
    assign ex_rd        = stage_q.rd;
    assign ex_reg_write = stage_q.valid & stage_q.reg_write;
    assign ex_mem_read  = stage_q.valid & stage_q.mem_read;
    assign ex_mem_write = stage_q.valid & stage_q.mem_write;

    // rs2 is compared even for immediate forms; stalling conservatively is intended.
    assign ex_rd_hit = (stage_q.rd == id_rs1_addr) || (stage_q.rd == id_rs2_addr);
    assign load_use_hazard = id_valid && ex_valid && ex_mem_read &&
                             (stage_q.rd != '0) && ex_rd_hit;

    assign exmem_fwd_rs1 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == stage_q.rs1_addr);
    assign memwb_fwd_rs1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == stage_q.rs1_addr);
    assign exmem_fwd_rs2 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == stage_q.rs2_addr);
    assign memwb_fwd_rs2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == stage_q.rs2_addr);

    always_comb begin
        rs1_fwd = stage_q.rs1_data;
        if (exmem_fwd_rs1) begin
            rs1_fwd = exmem_result;
        end else if (memwb_fwd_rs1) begin
            rs1_fwd = memwb_result;
        end

        rs2_fwd = stage_q.rs2_data;
        if (exmem_fwd_rs2) begin
            rs2_fwd = exmem_result;
        end else if (memwb_fwd_rs2) begin
            rs2_fwd = memwb_result;
        end
    end

    assign ex_a          = rs1_fwd;
    assign ex_b          = stage_q.use_imm ? stage_q.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;

    always_comb begin
        stage_d = stage_q;
        if (flush || (!stall && load_use_hazard)) begin
            // Bubble: kill the instruction but leave the datapath fields alone.
            stage_d.valid     = 1'b0;
            stage_d.reg_write = 1'b0;
            stage_d.mem_read  = 1'b0;
            stage_d.mem_write = 1'b0;
        end else if (!stall) begin
            stage_d.valid     = id_valid;
            stage_d.rs1_addr  = id_rs1_addr;
            stage_d.rs2_addr  = id_rs2_addr;
            stage_d.rs1_data  = id_rs1_data;
            stage_d.rs2_data  = id_rs2_data;
            stage_d.imm       = id_imm;
            stage_d.use_imm   = id_use_imm;
            stage_d.alu_ctrl  = id_alu_ctrl;
            stage_d.rd        = id_rd;
            stage_d.reg_write = id_reg_write;
            stage_d.mem_read  = id_mem_read;
            stage_d.mem_write = id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the stage contents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;

    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .stall           (stall),
        .flush           (flush),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ex_a            (ex_a),
        .ex_b            (ex_b),
        .ex_alu_ctrl     (ex_alu_ctrl),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .load_use_hazard (load_use_hazard)
    );

    // Model of what instruction EX currently holds.
    typedef struct {
        bit          valid;
        bit [4:0]    rs1, rs2, rd;
        bit [31:0]   d1, d2, imm;
        bit          use_imm;
        bit [3:0]    ctrl;
        bit          rw, mr, mw;
    } instr_t;

    instr_t ex_m;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [31:0] operand(input bit [4:0] src, input bit [31:0] regval);
        if (src == 0) return regval;
        if (exmem_reg_write && exmem_rd == src) return exmem_result;
        if (memwb_reg_write && memwb_rd == src) return memwb_result;
        return regval;
    endfunction

    function automatic bit model_hazard();
        return id_valid && ex_m.valid && ex_m.mr && ex_m.rd != 0 &&
               (ex_m.rd == id_rs1_addr || ex_m.rd == id_rs2_addr);
    endfunction

    task automatic check_all();
        bit [31:0] a, s;
        a = operand(ex_m.rs1, ex_m.d1);
        s = operand(ex_m.rs2, ex_m.d2);
        check_eq("ex_valid", ex_valid, ex_m.valid);
        check_eq("ex_a", ex_a, a);
        check_eq("ex_b", ex_b, ex_m.use_imm ? ex_m.imm : s);
        check_eq("ex_store_data", ex_store_data, s);
        check_eq("ex_alu_ctrl", ex_alu_ctrl, ex_m.ctrl);
        check_eq("ex_rd", ex_rd, ex_m.rd);
        check_eq("ex_reg_write", ex_reg_write, ex_m.valid & ex_m.rw);
        check_eq("ex_mem_read", ex_mem_read, ex_m.valid & ex_m.mr);
        check_eq("ex_mem_write", ex_mem_write, ex_m.valid & ex_m.mw);
        check_eq("load_use_hazard", load_use_hazard, model_hazard());
    endtask

    function automatic void model_edge();
        bit hz;
        hz = model_hazard();
        if (rst) begin
            ex_m = '{default: 0};
        end else if (flush || (!stall && hz)) begin
            ex_m.valid = 0; ex_m.rw = 0; ex_m.mr = 0; ex_m.mw = 0;
        end else if (!stall) begin
            ex_m.valid = id_valid;    ex_m.rs1 = id_rs1_addr; ex_m.rs2 = id_rs2_addr;
            ex_m.d1 = id_rs1_data;    ex_m.d2 = id_rs2_data;  ex_m.imm = id_imm;
            ex_m.use_imm = id_use_imm; ex_m.ctrl = id_alu_ctrl; ex_m.rd = id_rd;
            ex_m.rw = id_reg_write;   ex_m.mr = id_mem_read;  ex_m.mw = id_mem_write;
        end
    endfunction

    // Inputs are set by the caller just after a falling edge; check, take the edge, return.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input bit [4:0] r1, input bit [4:0] r2,
                          input bit [31:0] d1, input bit [31:0] d2, input bit [31:0] imm,
                          input bit ui, input bit [4:0] rd, input bit rw, input bit mr);
        id_valid = v; id_rs1_addr = r1; id_rs2_addr = r2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = imm; id_use_imm = ui; id_alu_ctrl = 4'd0; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    endtask

    logic [4:0]  held_rd;
    logic [31:0] held_a;

    initial begin
        ex_m = '{default: 0};
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(1, 5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 1'b0, 5'd9, 1'b1, 1'b1);
        id_alu_ctrl = 4'd3; id_mem_write = 1'b1;
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 32'h0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'h0;
        @(negedge clk);

        // Reset for two cycles with live decode inputs.
        @(posedge clk); model_edge(); @(negedge clk);
        @(posedge clk); model_edge(); @(negedge clk);
        #1;
        check_eq("rst ex_a", ex_a, 0);
        check_eq("rst ex_b", ex_b, 0);
        check_eq("rst ex_valid", ex_valid, 0);
        check_eq("rst hazard", load_use_hazard, 0);
        rst = 1'b0;

        // Plain load of an immediate-form instruction.
        set_id(1, 5'd1, 5'd2, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3, 1'b1, 1'b0);
        cycle();
        check_eq("load ex_a", ex_a, 32'd5);
        check_eq("load ex_b", ex_b, 32'd7);
        check_eq("load ex_rd", ex_rd, 5'd3);
        check_eq("load ex_valid", ex_valid, 1);

        // Forwarding priority while the instruction is held.
        set_id(1, 5'd4, 5'd5, 32'h11, 32'h55, 32'h0, 1'b0, 5'd7, 1'b1, 1'b0);
        cycle();
        stall = 1'b1; id_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
        #1 check_eq("fwd exmem", ex_a, 32'hAA);
        exmem_reg_write = 1'b0;
        #1 check_eq("fwd memwb", ex_a, 32'hBB);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1 check_eq("fwd none", ex_a, 32'h11);
        cycle();
        stall = 1'b0; exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // Load-use on rs2 of the following instruction.
        set_id(1, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 5'd6, 1'b1, 1'b1);
        cycle();
        set_id(1, 5'd1, 5'd6, 32'h1, 32'h2, 32'h0, 1'b0, 5'd2, 1'b1, 1'b0);
        #1 check_eq("lu hazard", load_use_hazard, 1);
        cycle();
        check_eq("lu bubble valid", ex_valid, 0);
        check_eq("lu bubble rw", ex_reg_write, 0);

        // Stall holds for three cycles, then flush beats stall.
        cycle();
        held_rd = ex_rd; held_a = ex_a;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'(i + 8), 5'd9, $urandom, $urandom, $urandom, 1'b0, 5'(i + 20),
                   1'b1, 1'b0);
            cycle();
            check_eq("stall rd", ex_rd, held_rd);
            check_eq("stall a", ex_a, held_a);
        end
        flush = 1'b1;
        cycle();
        check_eq("flush+stall valid", ex_valid, 0);
        flush = 1'b0; stall = 1'b0;

        // A load to x0 never raises a hazard, and x0 is never forwarded.
        set_id(1, 5'd0, 5'd0, 32'h33, 32'h44, 32'h0, 1'b0, 5'd0, 1'b1, 1'b1);
        cycle();
        set_id(1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 1'b1, 1'b0);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hEE;
        #1;
        check_eq("x0 hazard", load_use_hazard, 0);
        check_eq("x0 ex_a", ex_a, 32'h33);
        check_eq("x0 store", ex_store_data, 32'h44);
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 11) == 0);
            stall = ($urandom_range(0, 5) == 0);
            set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom));
            id_alu_ctrl     = 4'($urandom_range(0, 6));
            id_mem_write    = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_rd        = 5'($urandom_range(0, 7));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd        = 5'($urandom_range(0, 7));
            memwb_result    = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
